// File: rtl/multicycle_datapath_pkg.sv
// Shared constants for the multi-cycle 8-bit-instruction CPU core:
// opcode/funct encodings, FSM state encoding and instruction field positions.
package multicycle_datapath_pkg;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_LW   = 2'b10;
  localparam logic [1:0] OP_SW   = 2'b11;

  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_SUB = 2'b01;
  localparam logic [1:0] FN_AND = 2'b10;
  localparam logic [1:0] FN_OR  = 2'b11;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  typedef enum logic [2:0] {
    ST_FETCH  = S_FETCH,
    ST_DECODE = S_DECODE,
    ST_EXEC   = S_EXEC,
    ST_MEM    = S_MEM,
    ST_WB     = S_WB
  } state_e;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int RS_MSB  = 5;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 2;
  localparam int IMM_MSB = 1;
  localparam int IMM_LSB = 0;

  localparam int NUM_REGS = 4;

endpackage

// File: rtl/multicycle_datapath_alu.sv
// Combinational ALU for the multi-cycle core: add, sub, and, or on DATA_W-bit
// operands, all arithmetic modulo 2^DATA_W.
module mcdp_alu
  import multicycle_datapath_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        fn,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (fn)
      FN_ADD:  y = a + b;
      FN_SUB:  y = a - b;
      FN_AND:  y = a & b;
      FN_OR:   y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB sequencing over external
// handshaked instruction and data memories. MULTICYCLE_DATAPATH_PERF_EN adds perf counters.
module multicycle_datapath
  import multicycle_datapath_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [7:0]        imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc_out_addr,
  output logic [7:0]        inst,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              retire
`ifdef MULTICYCLE_DATAPATH_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_retired
`endif
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic              retire_q, retire_d;

  logic [1:0]        opcode_s;
  logic [1:0]        rs_s;
  logic [1:0]        rt_s;
  logic [1:0]        funct_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic [DATA_W-1:0] alu_a_s, alu_b_s, alu_y_s;
  logic [1:0]        alu_fn_s;

  assign opcode_s  = ir_q[OP_MSB:OP_LSB];
  assign rs_s      = ir_q[RS_MSB:RS_LSB];
  assign rt_s      = ir_q[RT_MSB:RT_LSB];
  assign funct_s   = ir_q[IMM_MSB:IMM_LSB];
  assign imm_ext_s = {{(DATA_W-2){1'b0}}, ir_q[IMM_MSB:IMM_LSB]};

  // ADDI adds imm to A; loads and stores form their address from B + imm.
  always_comb begin
    alu_a_s  = a_q;
    alu_b_s  = b_q;
    alu_fn_s = FN_ADD;
    case (opcode_s)
      OP_ALU: begin
        alu_b_s  = b_q;
        alu_fn_s = funct_s;
      end
      OP_ADDI: alu_b_s = imm_ext_s;
      OP_LW, OP_SW: begin
        alu_a_s = b_q;
        alu_b_s = imm_ext_s;
      end
      default: alu_fn_s = FN_ADD;
    endcase
  end

  mcdp_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (alu_a_s),
    .b  (alu_b_s),
    .fn (alu_fn_s),
    .y  (alu_y_s)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    mdr_d    = mdr_q;
    rf_d     = rf_q;
    retire_d = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (enable && imem_ready) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        a_d     = rf_q[rs_s];
        b_d     = rf_q[rt_s];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_y_s;
        if (opcode_s == OP_LW || opcode_s == OP_SW) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // Request, address and data are registers, so they hold across wait states.
        if (dmem_ready) begin
          if (opcode_s == OP_SW) begin
            retire_d = 1'b1;
            pc_d     = pc_q + PC_W'(1);
            state_d  = ST_FETCH;
          end else begin
            mdr_d    = dmem_rdata;
            state_d  = ST_WB;
          end
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        if (opcode_s == OP_LW) begin
          rf_d[rs_s] = mdr_q;
        end else begin
          rf_d[rs_s] = result_q;
        end
        retire_d = 1'b1;
        pc_d     = pc_q + PC_W'(1);
        state_d  = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      ir_q     <= 8'h00;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      mdr_q    <= '0;
      retire_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      mdr_q    <= mdr_d;
      retire_q <= retire_d;
      rf_q     <= rf_d;
    end
  end

  // Requests are masked by reset so nothing is issued during the reset cycle.
  assign imem_req    = (state_q == ST_FETCH) && enable && !reset;
  assign imem_addr   = pc_q;
  assign dmem_req    = (state_q == ST_MEM) && !reset;
  assign dmem_we     = (state_q == ST_MEM) && (opcode_s == OP_SW);
  assign dmem_addr   = result_q;
  assign dmem_wdata  = a_q;
  assign pc_out_addr = pc_q;
  assign inst        = ir_q;
  assign result      = result_q;
  assign readData1   = a_q;
  assign readData2   = b_q;
  assign retire      = retire_q;

`ifdef MULTICYCLE_DATAPATH_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_retired_q, perf_retired_d;

  always_comb begin
    perf_cycles_d  = perf_cycles_q + 32'd1;
    perf_retired_d = perf_retired_q + (retire_d ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_q  <= 32'd0;
      perf_retired_q <= 32'd0;
    end else begin
      perf_cycles_q  <= perf_cycles_d;
      perf_retired_q <= perf_retired_d;
    end
  end

  assign perf_cycles  = perf_cycles_q;
  assign perf_retired = perf_retired_q;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Randomized scoreboard bench for multicycle_datapath: an instruction-level
// reference model predicts every retire and every data-memory access.
`timescale 1ns/1ps
module tb_multicycle_datapath;
  localparam int DATA_W = 8;
  localparam int PC_W   = 8;

  typedef struct {
    logic [7:0]        ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] res;
    logic [PC_W-1:0]   pc;
    int                lat;
    int                fcyc;
  } ret_t;

  typedef struct {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              imem_req, imem_ready = 1'b0;
  logic [PC_W-1:0]   imem_addr;
  logic [7:0]        imem_rdata = 8'h00;
  logic              dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [PC_W-1:0]   pc_out_addr;
  logic [7:0]        inst;
  logic [DATA_W-1:0] result, readData1, readData2;
  logic              retire;
`ifdef MULTICYCLE_DATAPATH_PERF_EN
  logic [31:0]       perf_cycles, perf_retired;
`endif

  multicycle_datapath #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc_out_addr(pc_out_addr), .inst(inst), .result(result),
    .readData1(readData1), .readData2(readData2), .retire(retire)
`ifdef MULTICYCLE_DATAPATH_PERF_EN
    , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int waits = 0;
  int im_mode = 0, dm_mode = 0, en_mode = 0;
  ret_t rq[$];
  mem_t mq[$];
  logic [DATA_W-1:0] m_regs [4];
  logic [DATA_W-1:0] m_mem [256];
  logic [DATA_W-1:0] dmem_arr [256];
  logic [7:0]        prog [256];
  logic [PC_W-1:0]   m_pc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference model, evaluated at fetch time.
  task automatic issue(input logic [7:0] ir);
    ret_t r;
    mem_t m;
    int op, rs, rt, fn;
    logic [DATA_W-1:0] imm;
    op = ir[7:6]; rs = ir[5:4]; rt = ir[3:2]; fn = ir[1:0];
    imm = DATA_W'(ir[1:0]);
    r.ir = ir; r.a = m_regs[rs]; r.b = m_regs[rt]; r.fcyc = cyc; r.lat = 4;
    case (op)
      0: begin
        case (fn)
          0: r.res = r.a + r.b;
          1: r.res = r.a - r.b;
          2: r.res = r.a & r.b;
          default: r.res = r.a | r.b;
        endcase
        m_regs[rs] = r.res;
      end
      1: begin
        r.res = r.a + imm;
        m_regs[rs] = r.res;
      end
      2: begin
        r.res = r.b + imm;
        m_regs[rs] = m_mem[r.res];
        r.lat = 5;
        m.we = 1'b0; m.addr = r.res; m.wdata = '0;
        mq.push_back(m);
      end
      default: begin
        r.res = r.b + imm;
        m_mem[r.res] = r.a;
        m.we = 1'b1; m.addr = r.res; m.wdata = r.a;
        mq.push_back(m);
      end
    endcase
    m_pc = m_pc + 1'b1;
    r.pc = m_pc;
    rq.push_back(r);
  endtask

  task automatic step(input logic rst);
    @(negedge clk);
    reset = rst;
    enable = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    imem_ready = (im_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    case (dm_mode)
      0: dmem_ready = 1'b1;
      1: dmem_ready = ($urandom_range(0, 2) != 0);
      default: dmem_ready = !dmem_we;
    endcase
    imem_rdata = prog[imem_addr];
    dmem_rdata = dmem_arr[dmem_addr];
    #1;
    if (reset) begin
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_pc = '0;
      m_mem = dmem_arr;
      rq.delete();
      mq.delete();
    end else begin
      if (imem_req && imem_ready) issue(imem_rdata);
      if (dmem_req && dmem_ready && dmem_we) dmem_arr[dmem_addr] = dmem_wdata;
    end
  endtask

  // Monitor: compares DUT activity against the queued expectations.
  always @(negedge clk) begin
    ret_t e;
    #2;
    if (reset === 1'b1) begin
      chk("req_during_reset", {30'd0, imem_req, dmem_req}, 32'd0);
      waits = 0;
    end else begin
      if (!enable) chk("imem_req_enable_low", {31'd0, imem_req}, 32'd0);
      if (dmem_req) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL dmem_unexpected: got addr %0h expected no access", dmem_addr);
        end else begin
          chk("dmem_we", {31'd0, dmem_we}, {31'd0, mq[0].we});
          chk("dmem_addr", dmem_addr, mq[0].addr);
          if (mq[0].we) chk("dmem_wdata", dmem_wdata, mq[0].wdata);
          if (dmem_ready) void'(mq.pop_front());
          else waits++;
        end
      end
      if (retire) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL retire_unexpected: got retire expected none");
        end else begin
          e = rq.pop_front();
          chk("inst", inst, e.ir);
          chk("readData1", readData1, e.a);
          chk("readData2", readData2, e.b);
          chk("result", result, e.res);
          chk("pc", pc_out_addr, e.pc);
          chk("latency", cyc - e.fcyc - waits, e.lat);
          waits = 0;
        end
      end
    end
  end

  task automatic check_reset_state();
    @(posedge clk);
    #1;
    chk("rst_pc", pc_out_addr, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd1", readData1, 32'd0);
    chk("rst_rd2", readData2, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
`ifdef MULTICYCLE_DATAPATH_PERF_EN
    chk("rst_perf_cycles", perf_cycles, 32'd0);
    chk("rst_perf_retired", perf_retired, 32'd0);
`endif
  endtask

  initial begin
    logic [PC_W-1:0] pc_hold;
    bit found;
    for (int i = 0; i < 256; i++) begin
      prog[i] = 8'($urandom);
      dmem_arr[i] = DATA_W'($urandom);
    end
    prog[0] = 8'h53; prog[1] = 8'h19; prog[2] = 8'hCD; prog[3] = 8'hAD;
    m_mem = dmem_arr;

    step(1'b1);
    check_reset_state();

    im_mode = 0; dm_mode = 0; en_mode = 0;
    repeat (60) step(1'b0);

    im_mode = 1; dm_mode = 1; en_mode = 1;
    repeat (2500) step(1'b0);

    en_mode = 2; dm_mode = 0;
    repeat (12) step(1'b0);
    pc_hold = pc_out_addr;
    repeat (6) step(1'b0);
    chk("pc_frozen_enable_low", pc_out_addr, pc_hold);
    chk("drained_enable_low", rq.size(), 32'd0);
    en_mode = 0;

    dm_mode = 2; found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1'b0);
      if (dmem_req && dmem_we) found = 1;
    end
    chk("sw_reached", {31'd0, found}, 32'd1);
    repeat (3) step(1'b0);
    step(1'b1);
    check_reset_state();

    dm_mode = 1; im_mode = 1; en_mode = 1;
    repeat (600) step(1'b0);

    en_mode = 2; dm_mode = 0;
    for (int i = 0; i < 60 && rq.size() != 0; i++) step(1'b0);
    chk("final_drain", rq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
